// File: rtl/regfile_scoreboard.sv
// Register file (2^ADDR_W x WIDTH) with post-reset clear engine and per-register busy scoreboard.
// Latency: combinational reads, writes/reserves visible one edge later; output_ready after DEPTH edges.
// Backpressure: none; writes and reserves are dropped while clearing. Optional macro: REGFILE_BYPASS_EN.
module regfile_scoreboard #(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] input_reg_readA_address,
    input  logic [ADDR_W-1:0] input_reg_readB_address,
    input  logic              input_reg_write,
    input  logic [ADDR_W-1:0] input_reg_write_address,
    input  logic [WIDTH-1:0]  input_reg_write_value,
    input  logic              input_reg_reserve,
    input  logic [ADDR_W-1:0] input_reg_reserve_address,
    output logic [WIDTH-1:0]  output_reg_A,
    output logic [WIDTH-1:0]  output_reg_B,
    output logic              output_reg_A_busy,
    output logic              output_reg_B_busy,
    output logic              output_ready
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W:0]   clr_idx;
    logic [ADDR_W:0]   clr_idx_nxt;
    logic [WIDTH-1:0]  regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              wr_en;
    logic              rsv_en;
    logic [ADDR_W-1:0] rd_addr [2];
    logic [WIDTH-1:0]  rd_dat  [2];
    logic              rd_bsy  [2];

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        if (state == CLEAR) begin
            clr_idx_nxt = clr_idx + 1'b1;
            if (clr_idx == LAST_IDX) begin
                state_nxt = READY;
            end
        end
    end

    // Hard-wired zero register swallows writes and reserves so it never goes busy.
    assign wr_en  = (state == READY) && input_reg_write &&
                    !((ZERO_REG != 0) && (input_reg_write_address == '0));
    assign rsv_en = (state == READY) && input_reg_reserve &&
                    !((ZERO_REG != 0) && (input_reg_reserve_address == '0));

    // Contents deliberately survive Reset; only the clear walk zeroes them.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            if (state == CLEAR) begin
                regs[clr_idx[ADDR_W-1:0]] <= '0;
            end else if (wr_en) begin
                regs[input_reg_write_address] <= input_reg_write_value;
            end
        end
    end

    // Reserve is applied after the write so a same-address pair leaves the newer producer pending.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            busy <= '0;
        end else begin
            if (wr_en) begin
                busy[input_reg_write_address] <= 1'b0;
            end
            if (rsv_en) begin
                busy[input_reg_reserve_address] <= 1'b1;
            end
        end
    end

    assign rd_addr[0] = input_reg_readA_address;
    assign rd_addr[1] = input_reg_readB_address;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_dat[p] = regs[rd_addr[p]];
            rd_bsy[p] = busy[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
            if ((state == READY) && input_reg_write &&
                (rd_addr[p] == input_reg_write_address)) begin
                rd_dat[p] = input_reg_write_value;
                rd_bsy[p] = input_reg_reserve &&
                            (input_reg_reserve_address == rd_addr[p]);
            end
`endif
            if ((state != READY) || ((ZERO_REG != 0) && (rd_addr[p] == '0))) begin
                rd_dat[p] = '0;
                rd_bsy[p] = 1'b0;
            end
        end
    end

    assign output_reg_A      = rd_dat[0];
    assign output_reg_B      = rd_dat[1];
    assign output_reg_A_busy = rd_bsy[0];
    assign output_reg_B_busy = rd_bsy[1];
    assign output_ready      = (state == READY);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench: two instances (ZERO_REG=0 and ZERO_REG=1) on shared stimulus, checked each cycle against a counting model.
module tb_regfile_scoreboard;

    localparam int DEPTH = 8;

    logic        CLK;
    logic        Reset;
    logic [2:0]  ra, rb, wa, rsa;
    logic        wr, rsv;
    logic [15:0] wv;

    logic [15:0] a_dat [2];
    logic [15:0] b_dat [2];
    logic        a_bsy [2];
    logic        b_bsy [2];
    logic        rdy   [2];

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] m_regs [DEPTH];
    logic [DEPTH-1:0] m_busy;
    int          m_cnt = 0;
    bit          model_valid = 0;

    regfile_scoreboard #(.WIDTH(16), .ADDR_W(3), .ZERO_REG(0)) dut (
        .CLK(CLK), .Reset(Reset),
        .input_reg_readA_address(ra), .input_reg_readB_address(rb),
        .input_reg_write(wr), .input_reg_write_address(wa), .input_reg_write_value(wv),
        .input_reg_reserve(rsv), .input_reg_reserve_address(rsa),
        .output_reg_A(a_dat[0]), .output_reg_B(b_dat[0]),
        .output_reg_A_busy(a_bsy[0]), .output_reg_B_busy(b_bsy[0]),
        .output_ready(rdy[0])
    );

    regfile_scoreboard #(.WIDTH(16), .ADDR_W(3), .ZERO_REG(1)) dut_z (
        .CLK(CLK), .Reset(Reset),
        .input_reg_readA_address(ra), .input_reg_readB_address(rb),
        .input_reg_write(wr), .input_reg_write_address(wa), .input_reg_write_value(wv),
        .input_reg_reserve(rsv), .input_reg_reserve_address(rsa),
        .output_reg_A(a_dat[1]), .output_reg_B(b_dat[1]),
        .output_reg_A_busy(a_bsy[1]), .output_reg_B_busy(b_bsy[1]),
        .output_ready(rdy[1])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Ready means DEPTH clean edges since the last reset; at that point every register is zero.
    task automatic model_update();
        if (Reset) begin
            m_cnt       = 0;
            m_busy      = '0;
            model_valid = 1;
        end else if (model_valid) begin
            if (m_cnt < DEPTH) begin
                m_cnt++;
                if (m_cnt == DEPTH) begin
                    for (int i = 0; i < DEPTH; i++) m_regs[i] = 16'h0000;
                end
            end else begin
                if (wr) begin
                    m_regs[wa] = wv;
                    m_busy[wa] = 1'b0;
                end
                if (rsv) m_busy[rsa] = 1'b1;
            end
        end
    endtask

    function automatic logic [16:0] exp_read(input int z, input logic [2:0] addr);
        if (m_cnt < DEPTH) return 17'h0;
        if (z == 1 && addr == 3'd0) return 17'h0;
`ifdef REGFILE_BYPASS_EN
        if (wr && addr == wa) return {rsv && (rsa == addr), wv};
`endif
        return {m_busy[addr], m_regs[addr]};
    endfunction

    always @(negedge CLK) begin
        if (model_valid) begin
            for (int z = 0; z < 2; z++) begin
                logic [16:0] ea, eb;
                ea = exp_read(z, ra);
                eb = exp_read(z, rb);
                chk($sformatf("ready_dut%0d", z), 32'(rdy[z]), 32'(m_cnt >= DEPTH));
                chk($sformatf("A_dat_dut%0d", z), 32'(a_dat[z]), 32'(ea[15:0]));
                chk($sformatf("B_dat_dut%0d", z), 32'(b_dat[z]), 32'(eb[15:0]));
                chk($sformatf("A_busy_dut%0d", z), 32'(a_bsy[z]), 32'(ea[16]));
                chk($sformatf("B_busy_dut%0d", z), 32'(b_bsy[z]), 32'(eb[16]));
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic idle();
        wr  = 1'b0;
        rsv = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; ra = 0; rb = 0; wa = 0; rsa = 0; wr = 0; rsv = 0; wv = 0;
        cyc(); cyc();
        Reset = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            cyc(); #2;
            chk("ready_after_clear_edge", 32'(rdy[0]), 32'(i == DEPTH));
            if (i == 1) chk("clear_read_zero", 32'(a_dat[0]), 32'h0);
        end

        // r1 write, visible only after the edge unless bypassing
        ra = 3'd1; wr = 1; wa = 3'd1; wv = 16'h1234; #2;
`ifdef REGFILE_BYPASS_EN
        chk("r1_same_cycle", 32'(a_dat[0]), 32'h1234);
`else
        chk("r1_same_cycle", 32'(a_dat[0]), 32'h0000);
`endif
        cyc(); idle(); #2;
        chk("r1_after_edge", 32'(a_dat[0]), 32'h1234);

        rb = 3'd1; ra = 3'd2; wr = 1; wa = 3'd2; wv = 16'hABCD; #2;
        chk("B_r1_during_r2_write", 32'(b_dat[0]), 32'h1234);
        cyc(); idle(); #2;
        chk("r2_after_edge", 32'(a_dat[0]), 32'hABCD);

        ra = 3'd3; rsv = 1; rsa = 3'd3; cyc(); idle(); #2;
        chk("r3_busy", 32'(a_bsy[0]), 32'h1);
        wr = 1; wa = 3'd3; wv = 16'h00FF; cyc(); idle(); #2;
        chk("r3_busy_cleared", 32'(a_bsy[0]), 32'h0);
        chk("r3_data", 32'(a_dat[0]), 32'h00FF);

        ra = 3'd4; wr = 1; wa = 3'd4; wv = 16'h4444; rsv = 1; rsa = 3'd4;
        cyc(); idle(); #2;
        chk("r4_data", 32'(a_dat[0]), 32'h4444);
        chk("r4_busy", 32'(a_bsy[0]), 32'h1);

        ra = 3'd0; wr = 1; wa = 3'd0; wv = 16'hFFFF; rsv = 1; rsa = 3'd0;
        cyc(); idle(); #2;
        chk("zero_reg_data", 32'(a_dat[1]), 32'h0);
        chk("zero_reg_busy", 32'(a_bsy[1]), 32'h0);
        chk("plain_r0_data", 32'(a_dat[0]), 32'hFFFF);
        chk("plain_r0_busy", 32'(a_bsy[0]), 32'h1);

        ra = 3'd6; wr = 1; wa = 3'd6; wv = 16'h5A5A; #2;
`ifdef REGFILE_BYPASS_EN
        chk("r6_bypass", 32'(a_dat[0]), 32'h5A5A);
`else
        chk("r6_no_bypass", 32'(a_dat[0]), 32'h0000);
`endif
        chk("r6_busy_pre", 32'(a_bsy[0]), 32'h0);
        cyc(); idle(); #2;
        chk("r6_after_edge", 32'(a_dat[0]), 32'h5A5A);

        // Reset from READY, then a restart at clear index 5 with writes hammering r1
        wr = 1; wa = 3'd1; wv = 16'h7777; Reset = 1; ra = 3'd1;
        cyc(); #2;
        chk("ready_drop_on_reset", 32'(rdy[0]), 32'h0);
        Reset = 0;
        for (int i = 0; i < 5; i++) cyc();
        Reset = 1; cyc(); Reset = 0;
        for (int i = 1; i <= DEPTH; i++) begin
            cyc(); #2;
            chk("ready_after_restart", 32'(rdy[0]), 32'(i == DEPTH));
        end
        wr = 0; #1;
        chk("r1_cleared_not_written", 32'(a_dat[0]), 32'h0);

        for (int n = 0; n < 3000; n++) begin
            Reset = ($urandom_range(0, 149) == 0);
            ra  = 3'($urandom_range(0, 7));
            rb  = 3'($urandom_range(0, 7));
            wa  = 3'($urandom_range(0, 7));
            rsa = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
            wr  = $urandom_range(0, 1) == 1;
            rsv = $urandom_range(0, 2) == 0;
            wv  = 16'($urandom);
            cyc();
        end
        Reset = 0; idle();
        cyc(); #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised successor to the 8×16 programmable register file of the multi-cycle datapath. It holds 2^ADDR_W registers of WIDTH bits, with two asynchronous read ports and one clocked write port. It adds a post-reset sequential clear engine, a ready flag, an optional hard-wired zero register and a per-register busy scoreboard, so the control FSM can stall on operands that still have a write outstanding.

## Interface
- WIDTH, 16, register data width in bits
- ADDR_W, 3, address width; DEPTH = 2^ADDR_W registers
- ZERO_REG, 0, when 1, register 0 always reads 0 and is never busy; writes and reserves to it are ignored
- CLK  input  1  clock; all state updates on the rising edge
- Reset  input  1  synchronous, active-high reset
- input_reg_readA_address  input  ADDR_W  read port A address
- input_reg_readB_address  input  ADDR_W  read port B address
- input_reg_write  input  1  write enable
- input_reg_write_address  input  ADDR_W  write address
- input_reg_write_value  input  WIDTH  write data
- input_reg_reserve  input  1  mark a register busy (producer issued)
- input_reg_reserve_address  input  ADDR_W  register to mark busy
- output_reg_A  output  WIDTH  read port A data
- output_reg_B  output  WIDTH  read port B data
- output_reg_A_busy  output  1  busy bit of the register addressed by port A
- output_reg_B_busy  output  1  busy bit of the register addressed by port B
- output_ready  output  1  clear sequence finished; the file is usable

## Operation
- FSM states: CLEAR and READY.
- Any edge with Reset=1 does all of the following:
  - state ← CLEAR
  - clear index ← 0
  - all busy bits ← 0
  - output_ready ← 0
- CLEAR, Reset=0:
  - Each edge writes 0 to register[index] and increments the index.
  - The edge that writes index DEPTH−1 moves to READY and sets output_ready ← 1.
- CLEAR behaviour for external requests:
  - Writes and reserves are ignored.
  - Read data is forced to 0 and busy outputs to 0.
- READY:
  - Write: if input_reg_write=1, then on the edge register[write_address] ← write_value and busy[write_address] ← 0.
  - Reserve: if input_reg_reserve=1, then on the edge busy[reserve_address] ← 1.
  - Reserve and write to the same address in one cycle: data is written and busy ends at 1, because the reserve is from a newer producer.
  - Reserve and write to different addresses are independent.
- Reads are combinational: output_reg_X = register[readX_address]; output_reg_X_busy = busy[readX_address].
- ZERO_REG=1: the address-0 override applies in every state.
- Registers are never cleared by Reset itself; only the CLEAR sequence zeroes them.

## Timing
- Reset values: output_ready=0; output_reg_A/B=0 and busy outputs=0 while in CLEAR.
- Clear latency:
  - output_ready rises after exactly DEPTH rising edges with Reset=0 following the last Reset=1 edge.
  - This is 8 cycles at the defaults.
- Reset asserted mid-clear restarts the index at 0 and the full DEPTH count.
- Reset asserted in READY returns to CLEAR on that edge.
- Write-to-read latency: the value is visible on the read port immediately after the write edge. Without BYPASS_EN it is not visible in the same cycle.
- Busy set and clear take effect on the edge; the busy output reflects them in the following cycle.
- Index arithmetic is ADDR_W+1 bits wide, so there is no wrap before the terminal compare.

## Configuration
- REGFILE_BYPASS_EN defined:
  - In READY, a read port whose address equals write_address while input_reg_write=1 returns input_reg_write_value combinationally in the same cycle.
  - That port's busy output reads 0, unless a same-address reserve is also active.
  - ZERO_REG masking still overrides the bypass for address 0.
- REGFILE_BYPASS_EN not defined: reads always return stored contents; there is no same-cycle forwarding.

## Test plan
- Reset 2 cycles, then release: output_ready stays 0 for 8 edges and goes 1 after the 8th; all reads return 16'h0000.
- In READY, write 16'h1234 to r1, then read A=r1: 16'h1234 on the cycle after the write edge. Write 16'hABCD to r2 while B=r1: B stays 16'h1234, and A=r2 afterwards gives 16'hABCD.
- Reserve r3, read A=r3: busy=1. Write 16'h00FF to r3: busy=0 and data 16'h00FF. Reserve and write r4 in the same cycle: data written, busy=1.
- ZERO_REG=1: write 16'hFFFF to r0 and reserve r0: A=r0 reads 16'h0000 with busy=0.
- Reset pulse at clear index 5: output_ready rises 8 edges after the pulse, not 3. Write attempts during CLEAR leave the registers at 0.
- With REGFILE_BYPASS_EN: write 16'h5A5A to r6 with A=r6 in the same cycle gives A=16'h5A5A before the edge. Without the macro, A shows the old value until after the edge.
